traffic_req_gen: RTL and testbench

Upstream request generator for the traffic-light controller. Conditions the raw side-road vehicle-loop sensor (synchronise, debounce, edge-detect) and counts waiting vehicles. Asserts the controller's request input `c` once enough vehicles queue or one has waited too long. Drops `c` when the controller reports the side road is being served.

---
 rtl/traffic_req_gen.sv | 130 +++++++++++++
 tb/tb_traffic_req_gen.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/traffic_req_gen.sv
// Side-road request generator: synchronises and debounces the vehicle-loop sensor,
// counts arrivals and raises the controller request on queue length or wait timeout.
module traffic_req_gen #(
    parameter int DEB_CYCLES = 4,
    parameter int CNT_W      = 4,
    parameter int THRESH     = 3,
    parameter int WAIT_MAX   = 40
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sensor_raw,
    input  logic             serve,
    output logic             c,
    output logic [CNT_W-1:0] car_cnt,
    output logic             pending,
    output logic             sensor_db
);

    localparam int DEB_W = (DEB_CYCLES < 2) ? 1 : $clog2(DEB_CYCLES + 1);
    localparam int TMR_W = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);

    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(THRESH);
    localparam logic [TMR_W-1:0] TMR_MAX  = TMR_W'(WAIT_MAX);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_REQ,
        ST_SERVED
    } state_t;

    state_t           state_q, state_d;
    logic             s1_q, s2_q;
    logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
    logic             db_q, db_d;
    logic [CNT_W-1:0] car_cnt_q, car_cnt_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             arrival;

    // A mismatch that survives DEB_CYCLES consecutive edges is accepted; any match restarts the count.
    always_comb begin
        deb_cnt_d = '0;
        db_d      = db_q;
        arrival   = 1'b0;
        if (s2_q != db_q) begin
            if (deb_cnt_q == DEB_LAST) begin
                db_d    = s2_q;
                arrival = s2_q;
            end else begin
                deb_cnt_d = deb_cnt_q + DEB_W'(1);
            end
        end
    end

    always_comb begin
        car_cnt_d = car_cnt_q;
        if (serve) begin
            car_cnt_d = '0;
        end else if (arrival && (car_cnt_q != CNT_MAX)) begin
            car_cnt_d = car_cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        unique case (state_q)
            ST_IDLE: begin
                timer_d = '0;
                if (!serve && (car_cnt_q != '0)) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (timer_q != TMR_MAX) begin
                    timer_d = timer_q + TMR_W'(1);
                end
                // Serve wins over a simultaneous threshold/timeout so c never pulses.
                if (serve) begin
                    state_d = ST_IDLE;
                end else if ((car_cnt_q >= THRESH_C) || (timer_q == TMR_MAX)) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (serve) begin
                    state_d = ST_SERVED;
                end
            end
            ST_SERVED: begin
                timer_d = '0;
                if (!serve) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                timer_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            deb_cnt_q <= '0;
            db_q      <= 1'b0;
            car_cnt_q <= '0;
            timer_q   <= '0;
        end else begin
            state_q   <= state_d;
            s1_q      <= sensor_raw;
            s2_q      <= s1_q;
            deb_cnt_q <= deb_cnt_d;
            db_q      <= db_d;
            car_cnt_q <= car_cnt_d;
            timer_q   <= timer_d;
        end
    end

    assign c         = (state_q == ST_REQ);
    assign pending   = (state_q == ST_WAIT) || (state_q == ST_REQ);
    assign car_cnt   = car_cnt_q;
    assign sensor_db = db_q;

endmodule

// File: tb/tb_traffic_req_gen.sv
// Scoreboard bench for traffic_req_gen: stimulus queues cycle-stamped expectations,
// monitors compare outputs at the falling edge (and once mid-cycle for async reset).
module tb_traffic_req_gen;

    logic       clk;
    logic       rst;
    logic       sensor_raw;
    logic       serve;
    logic       c;
    logic [3:0] car_cnt;
    logic       pending;
    logic       sensor_db;

    traffic_req_gen #(
        .DEB_CYCLES(4),
        .CNT_W     (4),
        .THRESH    (3),
        .WAIT_MAX  (40)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sensor_raw(sensor_raw),
        .serve     (serve),
        .c         (c),
        .car_cnt   (car_cnt),
        .pending   (pending),
        .sensor_db (sensor_db)
    );

    typedef struct {
        int         cyc;
        string      nm;
        logic       c;
        logic       p;
        logic       db;
        logic [3:0] cnt;
    } exp_t;

    exp_t sb_q[$];
    exp_t async_q[$];
    event probe_ev;
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic expect_at(input int at, input string nm, input logic c_e, input logic p_e,
                             input logic db_e, input logic [3:0] cnt_e);
        exp_t e;
        int   idx;
        e.cyc = at; e.nm = nm; e.c = c_e; e.p = p_e; e.db = db_e; e.cnt = cnt_e;
        idx = sb_q.size();
        while (idx > 0 && sb_q[idx-1].cyc > at) idx--;
        sb_q.insert(idx, e);
    endtask

    task automatic compare(input exp_t e);
        logic [6:0] act, req;
        act = {c, pending, sensor_db, car_cnt};
        req = {e.c, e.p, e.db, e.cnt};
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s @cyc %0d: got c=%0b pend=%0b db=%0b cnt=%0d, required c=%0b pend=%0b db=%0b cnt=%0d",
                     e.nm, cyc, c, pending, sensor_db, car_cnt, e.c, e.p, e.db, e.cnt);
        end
    endtask

    always @(negedge clk) begin
        while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
            if (sb_q[0].cyc < cyc) begin
                total++;
                bad++;
                $display("FAIL %s: check for cyc %0d missed at cyc %0d", sb_q[0].nm, sb_q[0].cyc, cyc);
                void'(sb_q.pop_front());
            end else begin
                compare(sb_q.pop_front());
            end
        end
    end

    initial begin
        forever begin
            @(probe_ev);
            while (async_q.size() > 0) compare(async_q.pop_front());
        end
    end

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int   k;
        exp_t ae;
        rst        = 1'b1;
        sensor_raw = 1'b0;
        serve      = 1'b0;

        // Reset held while inputs toggle, then released.
        @(negedge clk);
        k = cyc;
        for (int i = 1; i <= 12; i++) expect_at(k + i, "reset", 1'b0, 1'b0, 1'b0, 4'd0);
        for (int i = 0; i < 6; i++) begin
            sensor_raw = (i % 2 == 0);
            serve      = (i == 2 || i == 3);
            @(negedge clk);
        end
        sensor_raw = 1'b0;
        serve      = 1'b0;
        rst        = 1'b0;
        wait_neg(7);

        // Glitch: three cycles high never reaches the debounce limit.
        k = cyc;
        for (int i = 1; i <= 10; i++) expect_at(k + i, "glitch", 1'b0, 1'b0, 1'b0, 4'd0);
        sensor_raw = 1'b1;
        wait_neg(3);
        sensor_raw = 1'b0;
        wait_neg(11);

        // Threshold: three 8/8 pulses, then serve.
        k = cyc;
        expect_at(k + 5,  "thr_lat",   1'b0, 1'b0, 1'b0, 4'd0);
        expect_at(k + 6,  "thr_cnt1",  1'b0, 1'b0, 1'b1, 4'd1);
        expect_at(k + 7,  "thr_wait",  1'b0, 1'b1, 1'b1, 4'd1);
        expect_at(k + 21, "thr_pre2",  1'b0, 1'b1, 1'b0, 4'd1);
        expect_at(k + 22, "thr_cnt2",  1'b0, 1'b1, 1'b1, 4'd2);
        expect_at(k + 38, "thr_cnt3",  1'b0, 1'b1, 1'b1, 4'd3);
        expect_at(k + 39, "thr_req",   1'b1, 1'b1, 1'b1, 4'd3);
        expect_at(k + 41, "thr_serve", 1'b0, 1'b0, 1'b1, 4'd0);
        expect_at(k + 44, "thr_idle",  1'b0, 1'b0, 1'b1, 4'd0);
        expect_at(k + 47, "thr_quiet", 1'b0, 1'b0, 1'b0, 4'd0);
        for (int i = 0; i < 2; i++) begin
            sensor_raw = 1'b1; wait_neg(8);
            sensor_raw = 1'b0; wait_neg(8);
        end
        sensor_raw = 1'b1; wait_neg(8);
        sensor_raw = 1'b0;
        serve      = 1'b1; wait_neg(2);
        serve      = 1'b0; wait_neg(8);

        // Timeout: single vehicle, request after WAIT_MAX+1 cycles in WAIT.
        k = cyc;
        expect_at(k + 6,  "to_cnt1",  1'b0, 1'b0, 1'b1, 4'd1);
        expect_at(k + 7,  "to_wait",  1'b0, 1'b1, 1'b1, 4'd1);
        expect_at(k + 47, "to_pre",   1'b0, 1'b1, 1'b0, 4'd1);
        expect_at(k + 48, "to_req",   1'b1, 1'b1, 1'b0, 4'd1);
        expect_at(k + 60, "to_hold",  1'b1, 1'b1, 1'b0, 4'd1);
        expect_at(k + 61, "to_serve", 1'b0, 1'b0, 1'b0, 4'd0);
        expect_at(k + 63, "to_idle",  1'b0, 1'b0, 1'b0, 4'd0);
        sensor_raw = 1'b1; wait_neg(8);
        sensor_raw = 1'b0; wait_neg(52);
        serve      = 1'b1; wait_neg(1);
        serve      = 1'b0; wait_neg(5);

        // Collision: serve sampled on the same edge the timeout would fire.
        k = cyc;
        expect_at(k + 7, "col_wait", 1'b0, 1'b1, 1'b1, 4'd1);
        for (int d = 40; d <= 55; d++)
            expect_at(k + d, "collision", 1'b0, (d < 48), 1'b0, (d < 48) ? 4'd1 : 4'd0);
        sensor_raw = 1'b1; wait_neg(8);
        sensor_raw = 1'b0; wait_neg(39);
        serve      = 1'b1; wait_neg(1);
        serve      = 1'b0; wait_neg(9);

        // Saturation: 20 arrivals without serve.
        k = cyc;
        for (int i = 0; i < 20; i++)
            expect_at(k + 16 * i + 6, "sat_cnt", (i >= 3), (i >= 1), 1'b1, (i >= 14) ? 4'd15 : 4'(i + 1));
        expect_at(k + 319, "sat_final", 1'b1, 1'b1, 1'b0, 4'd15);
        repeat (20) begin
            sensor_raw = 1'b1; wait_neg(8);
            sensor_raw = 1'b0; wait_neg(8);
        end

        // Asynchronous reset mid-cycle, checked well before the next rising edge.
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        ae.cyc = cyc; ae.nm = "async_rst"; ae.c = 1'b0; ae.p = 1'b0; ae.db = 1'b0; ae.cnt = 4'd0;
        async_q.push_back(ae);
        -> probe_ev;
        wait_neg(2);
        rst = 1'b0;
        k = cyc;
        for (int i = 1; i <= 3; i++) expect_at(k + i, "post_rst", 1'b0, 1'b0, 1'b0, 4'd0);
        wait_neg(4);

        for (int i = 0; i < 20 && sb_q.size() > 0; i++) @(negedge clk);
        if (sb_q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_drain: got %0d pending, required 0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
